// File: rtl/seg7_display_sched.sv
// Sequences the shared 4-digit seven-segment driver between op-code display,
// countdown timer and error flash; owns hold, tick and blink timing.
module seg7_display_sched #(
    parameter int TICK_DIV      = 100_000_000,
    parameter int BLINK_DIV     = 25_000_000,
    parameter int ERR_BLINKS    = 3,
    parameter int OP_HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_req,
    input  logic [2:0] op_code,
    input  logic       cd_start,
    input  logic [3:0] cd_init,
    input  logic       cd_abort,
    input  logic       err_req,
    output logic       busy,
    output logic       cd_done,
    output logic       disp_en,
    output logic       disp_mode,
    output logic [2:0] disp_op_code,
    output logic [3:0] disp_digit
);

    typedef enum logic [1:0] {IDLE, OP, CD, ERR} state_t;

    localparam int MAX_DIV   = (TICK_DIV > BLINK_DIV) ? TICK_DIV : BLINK_DIV;
    localparam int CW        = $clog2(MAX_DIV) + 1;
    localparam int MAX_PHASE = (OP_HOLD_TICKS > 2 * ERR_BLINKS) ? OP_HOLD_TICKS : 2 * ERR_BLINKS;
    localparam int PW        = $clog2(MAX_PHASE) + 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] HOLD_LAST  = PW'(OP_HOLD_TICKS - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(2 * ERR_BLINKS - 1);

    localparam logic [2:0] ERR_SYMBOL = 3'd7;

    state_t        state;
    logic [CW-1:0] cyc_cnt;    // tick counter in OP/CD, blink counter in ERR
    logic [PW-1:0] phase_cnt;  // elapsed ticks in OP, elapsed half-periods in ERR

    logic tick;
    logic blink;

    assign tick  = (cyc_cnt == TICK_LAST);
    assign blink = (cyc_cnt == BLINK_LAST);

    // NOTE: every output is a register written in this one block with <=, so
    // all of them change together on the same edge as the state they describe.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears counters as well as outputs,
        // so a reset mid-countdown can never leave a pending cd_done behind.
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            phase_cnt    <= '0;
            busy         <= 1'b0;
            cd_done      <= 1'b0;
            disp_en      <= 1'b0;
            disp_mode    <= 1'b0;
            disp_op_code <= 3'd0;
            disp_digit   <= 4'd0;
        end else begin
            cd_done <= 1'b0;

            if (err_req) begin
                state        <= ERR;
                cyc_cnt      <= '0;
                phase_cnt    <= '0;
                busy         <= 1'b1;
                disp_en      <= 1'b1;
                disp_mode    <= 1'b0;
                disp_op_code <= ERR_SYMBOL;
                disp_digit   <= 4'd0;
            end else if (cd_start && state != ERR) begin
                state        <= CD;
                cyc_cnt      <= '0;
                phase_cnt    <= '0;
                busy         <= 1'b1;
                disp_en      <= 1'b1;
                disp_mode    <= 1'b1;
                disp_op_code <= 3'd0;
                disp_digit   <= cd_init;
            end else if (op_req && (state == IDLE || state == OP)) begin
                state        <= OP;
                cyc_cnt      <= '0;
                phase_cnt    <= '0;
                busy         <= 1'b1;
                disp_en      <= 1'b1;
                disp_mode    <= 1'b0;
                disp_op_code <= op_code;
                disp_digit   <= 4'd0;
            end else if (cd_abort && state == CD) begin
                state        <= IDLE;
                cyc_cnt      <= '0;
                busy         <= 1'b0;
                disp_en      <= 1'b0;
                disp_mode    <= 1'b0;
                disp_digit   <= 4'd0;
            end else begin
                case (state)
                    OP: begin
                        if (!tick) begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end else begin
                            cyc_cnt <= '0;
                            if (phase_cnt == HOLD_LAST) begin
                                state        <= IDLE;
                                phase_cnt    <= '0;
                                busy         <= 1'b0;
                                disp_en      <= 1'b0;
                                disp_op_code <= 3'd0;
                            end else begin
                                phase_cnt <= phase_cnt + PW'(1);
                            end
                        end
                    end
                    CD: begin
                        if (!tick) begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end else begin
                            cyc_cnt <= '0;
                            if (disp_digit == 4'd0) begin
                                state     <= IDLE;
                                cd_done   <= 1'b1;
                                busy      <= 1'b0;
                                disp_en   <= 1'b0;
                                disp_mode <= 1'b0;
                            end else begin
                                disp_digit <= disp_digit - 4'd1;
                            end
                        end
                    end
                    ERR: begin
                        if (!blink) begin
                            cyc_cnt <= cyc_cnt + CW'(1);
                        end else begin
                            cyc_cnt <= '0;
                            if (phase_cnt == HALF_LAST) begin
                                state        <= IDLE;
                                phase_cnt    <= '0;
                                busy         <= 1'b0;
                                disp_en      <= 1'b0;
                                disp_op_code <= 3'd0;
                            end else begin
                                phase_cnt <= phase_cnt + PW'(1);
                                disp_en   <= ~disp_en;
                            end
                        end
                    end
                    default: begin
                        cyc_cnt   <= '0;
                        phase_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
